// File: rtl/spike_latency_decoder_if.sv
// Single-beat AXI-stream carrying the decoded time-to-first-spike result.
`timescale 1ns/1ps
interface spike_latency_decoder_if #(
    parameter int unsigned DW = 10
) ();
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/spike_latency_decoder.sv
// Time-to-first-spike winner decoder: collects neuron first-spike latencies for one window,
// scans them one neuron per cycle, emits {timeout, min_latency, winner}, then pulses neuron_reset.
`timescale 1ns/1ps
module spike_latency_decoder #(
    parameter int unsigned N  = 10,
    parameter int unsigned TS = 16,
    parameter int unsigned TW = $clog2(TS + 1),
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    time_step,
    input  logic [N-1:0]            in_tvalid,
    input  logic [N*TW-1:0]         in_tdata,
    spike_latency_decoder_if.master out_axis,
    output logic                    neuron_reset,
    output logic                    busy
);
    localparam int unsigned DW = 1 + TW + IW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SCAN,
        S_OUTPUT,
        S_CLEAR
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   ts_q;
    logic [N-1:0]    snap_v_q;
    logic [TW-1:0]   snap_lat_q [N];
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   best_q;
    logic [IW-1:0]   win_q;
    logic [DW-1:0]   tdata_q;
    logic            tvalid_q;
    logic            nreset_q;
    logic            busy_q;

    logic [TW-1:0]   in_lat_c [N];
    logic            capture_c;
    logic            take_c;
    logic [TW-1:0]   best_d;
    logic [IW-1:0]   win_d;

    // Unpack the flat neuron latency bus.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_lat_c[i] = in_tdata[i*TW +: TW];
        end
    end

    // Window closes when every neuron has fired or the registered step count hit the limit.
    assign capture_c = (&in_tvalid) || (ts_q == TW'(TS));

    // Strict less-than keeps the earliest index on ties.
    always_comb begin
        take_c = snap_v_q[idx_q] && (snap_lat_q[idx_q] < best_q);
        best_d = take_c ? snap_lat_q[idx_q] : best_q;
        win_d  = take_c ? idx_q : win_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ts_q     <= '0;
            snap_v_q <= '0;
            for (int i = 0; i < N; i++) begin
                snap_lat_q[i] <= '0;
            end
            idx_q    <= '0;
            best_q   <= '0;
            win_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            nreset_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            nreset_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_COLLECT;
                        ts_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (capture_c) begin
                        state_q  <= S_SCAN;
                        snap_v_q <= in_tvalid;
                        for (int i = 0; i < N; i++) begin
                            snap_lat_q[i] <= in_lat_c[i];
                        end
                        idx_q  <= '0;
                        best_q <= '1;
                        win_q  <= '0;
                    end else if (time_step && (ts_q != TW'(TS))) begin
                        ts_q <= ts_q + TW'(1);
                    end
                end
                S_SCAN: begin
                    best_q <= best_d;
                    win_q  <= win_d;
                    if (idx_q == IW'(N - 1)) begin
                        // With no valid neuron best/winner stay at their all-ones/zero defaults.
                        state_q  <= S_OUTPUT;
                        tvalid_q <= 1'b1;
                        tdata_q  <= {~(|snap_v_q), best_d, win_d};
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_axis.tready) begin
                        state_q  <= S_CLEAR;
                        tvalid_q <= 1'b0;
                        nreset_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_axis.tvalid = tvalid_q;
    assign out_axis.tdata  = tdata_q;
    assign out_axis.tlast  = tvalid_q;
    assign neuron_reset    = nreset_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_spike_latency_decoder.sv
// Randomized bench for spike_latency_decoder against a time-to-first-spike reference model.
`timescale 1ns/1ps
module tb_spike_latency_decoder;
    localparam int unsigned N  = 10;
    localparam int unsigned TS = 16;
    localparam int unsigned TW = $clog2(TS + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = 1 + TW + IW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            time_step;
    logic [N-1:0]    in_tvalid;
    logic [N*TW-1:0] in_tdata;
    logic            neuron_reset;
    logic            busy;

    spike_latency_decoder_if #(.DW(DW)) axis_if ();

    spike_latency_decoder #(.N(N), .TS(TS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .time_step    (time_step),
        .in_tvalid    (in_tvalid),
        .in_tdata     (in_tdata),
        .out_axis     (axis_if.master),
        .neuron_reset (neuron_reset),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int nr_cnt = 0;
    int fire_at [N];
    int lat     [N];

    always @(posedge clk) if (neuron_reset) nr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Earliest first-spike wins; among equal latencies the lowest neuron index.
    function automatic logic [DW-1:0] model(input bit v[N], input int l[N]);
        int mn;
        int w;
        mn = -1;
        w  = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && (mn < 0 || l[i] < mn)) mn = l[i];
        if (mn < 0) return {1'b1, {TW{1'b1}}, IW'(0)};
        for (int i = N - 1; i >= 0; i--)
            if (v[i] && l[i] == mn) w = i;
        return {1'b0, TW'(mn), IW'(w)};
    endfunction

    task automatic drive_garbage(input bit noise);
        in_tvalid = N'($urandom);
        for (int i = 0; i < N; i++) in_tdata[i*TW +: TW] = TW'($urandom);
        time_step = 1'($urandom);
        start     = noise ? 1'($urandom) : 1'b0;
    endtask

    task automatic run_window(input int rdly, input bit noise, input int abort_k);
        int ts;
        int nr0;
        int k;
        bit exited;
        bit seen;
        bit sv [N];
        int sl [N];
        logic [DW-1:0] exp;
        nr0 = nr_cnt;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start = 1'b1; time_step = 1'($urandom); in_tvalid = '0; axis_if.tready = 1'b0;
        @(negedge clk);
        ts = 0; exited = 0;
        for (int c = 0; c < 200 && !exited; c++) begin
            if (c > 0) @(negedge clk);
            chk("collect_busy", busy, 1);
            start     = noise ? 1'($urandom) : 1'b0;
            time_step = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                in_tvalid[i]          = (fire_at[i] <= ts);
                in_tdata[i*TW +: TW]  = in_tvalid[i] ? TW'(lat[i]) : TW'($urandom);
            end
            if ((&in_tvalid) || ts == TS) begin
                exited = 1;
                for (int i = 0; i < N; i++) begin
                    sv[i] = in_tvalid[i];
                    sl[i] = lat[i];
                end
            end else if (time_step && ts < TS) begin
                ts++;
            end
        end
        if (!exited) begin
            chk("collect_exit", 0, 1);
            return;
        end
        exp  = model(sv, sl);
        seen = 0; k = 0;
        // k counts rising edges after the capture edge at which out_tvalid is sampled.
        while (!seen && k < 3 * N) begin
            @(negedge clk);
            k++;
            if (abort_k > 0 && k == abort_k) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                chk("abort_tvalid", axis_if.tvalid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_nreset", neuron_reset, 0);
                start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                chk("abort_idle_tvalid", axis_if.tvalid, 0);
                chk("abort_no_nreset", nr_cnt - nr0, 0);
                return;
            end
            seen = axis_if.tvalid;
            if (!seen) begin
                chk("scan_busy", busy, 1);
                drive_garbage(noise);
            end
        end
        chk("tvalid_edge", k, N + 1);
        if (!seen) return;
        for (int r = 0; r <= rdly; r++) begin
            if (r > 0) @(negedge clk);
            chk("out_tvalid", axis_if.tvalid, 1);
            chk("out_tdata", axis_if.tdata, exp);
            chk("out_tlast", axis_if.tlast, 1);
            chk("out_busy", busy, 1);
            chk("out_nreset", neuron_reset, 0);
            drive_garbage(noise);
            axis_if.tready = (r == rdly);
        end
        @(negedge clk);
        chk("clear_nreset", neuron_reset, 1);
        chk("clear_tvalid", axis_if.tvalid, 0);
        chk("clear_tlast", axis_if.tlast, 0);
        chk("clear_busy", busy, 1);
        axis_if.tready = 1'($urandom);
        start = noise ? 1'b1 : 1'b0;
        @(negedge clk);
        chk("idle_nreset", neuron_reset, 0);
        chk("idle_after_clear", busy, 0);
        chk("nreset_count", nr_cnt - nr0, 1);
        start = 1'b0; axis_if.tready = 1'b0;
    endtask

    task automatic set_t1();
        for (int i = 0; i < N; i++) begin
            fire_at[i] = 8;
            lat[i]     = 8;
        end
        lat[0] = 5; lat[1] = 3; lat[2] = 7; lat[3] = 3;
        for (int i = 0; i < 4; i++) fire_at[i] = lat[i];
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; time_step = 1'b0;
        in_tvalid = '0; in_tdata = '0; axis_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", axis_if.tvalid, 0);
        chk("rst_tlast", axis_if.tlast, 0);
        chk("rst_tdata", axis_if.tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nreset", neuron_reset, 0);
        reset = 1'b0;

        set_t1();
        run_window(2, 0, 0);

        for (int i = 0; i < N; i++) begin fire_at[i] = 99; lat[i] = 0; end
        fire_at[2] = 9; lat[2] = 9;
        run_window(0, 0, 0);

        for (int i = 0; i < N; i++) fire_at[i] = 99;
        run_window(1, 0, 0);

        set_t1();
        run_window(20, 0, 0);
        run_window(3, 1, 0);
        run_window(0, 1, 4);
        run_window(1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            bit early;
            early = ($urandom % 5) == 0;
            for (int i = 0; i < N; i++) begin
                fire_at[i] = early ? $urandom_range(1, 6) : $urandom_range(1, 22);
                lat[i]     = ($urandom % 2) ? ((fire_at[i] > TS) ? TS : fire_at[i])
                                            : $urandom_range(0, TS);
            end
            run_window($urandom_range(0, 4), 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
